// File: rtl/fdct_in_buf_if.sv
// Stream bundle for the FDCT input buffer.
//   pix_in/pix_valid/pix_ready : 8-bit pixel stream into the buffer (raster order)
//   row_vec/row_idx/row_last/row_valid/row_ready : float32 row vectors out
// master drives pixels and accepts rows; slave is the buffer itself.
interface fdct_in_buf_if;
    logic [7:0]       pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic [7:0][31:0] row_vec;
    logic [2:0]       row_idx;
    logic             row_last;
    logic             row_valid;
    logic             row_ready;

    modport master (
        output pix_in, pix_valid, row_ready,
        input  pix_ready, row_vec, row_idx, row_last, row_valid
    );

    modport slave (
        input  pix_in, pix_valid, row_ready,
        output pix_ready, row_vec, row_idx, row_last, row_valid
    );
endinterface

// File: rtl/fdct_in_buf.sv
// Front end of the FDCT datapath. Pixels arrive in raster order, are level
// shifted and converted exactly to float32, and are written into a ping-pong
// pair of 8x8 block banks. A full bank is streamed out as eight row vectors.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous soft clear, discards both banks and all counters
//   bus   : slave side of fdct_in_buf_if (pixel input stream, row output stream)
module fdct_in_buf #(
    parameter int unsigned LEVEL_SHIFT = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    fdct_in_buf_if.slave bus
);

    localparam logic [9:0] Shift = 10'(LEVEL_SHIFT);

    // Exact int-to-float: |v| <= 255 fits in 8 bits, so the mantissa never rounds.
    function automatic logic [31:0] to_fp32(input logic [7:0] pix);
        logic signed [9:0] v;
        logic [7:0]        m;
        logic [2:0]        p;
        logic [22:0]       man;
        logic [7:0]        exp_f;
        logic [31:0]       res;
        v = $signed({2'b00, pix}) - $signed(Shift);
        m = v[9] ? 8'(-v) : v[7:0];
        p = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = 3'(i);
        end
        // Shift the leading one out of the top so the bits below it are left-aligned.
        man   = {m, 15'b0} << (4'd8 - {1'b0, p});
        exp_f = 8'd127 + {5'b0, p};
        res   = (m == 8'd0) ? 32'h0000_0000 : {v[9], exp_f, man};
        return res;
    endfunction

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [5:0] wr_cnt_q, wr_cnt_d;
    logic [2:0] rd_row_q, rd_row_d;

    // Address = {bank, row, col}.
    logic [31:0] mem_q [128];

    logic             pix_ready_c;
    logic             row_valid_c;
    logic             pix_acc;
    logic             row_acc;
    logic [31:0]      wr_data;
    logic [6:0]       wr_addr;
    logic [7:0][31:0] row_vec_c;

    always_comb begin
        pix_ready_c = ~full_q[wr_bank_q];
        row_valid_c = full_q[rd_bank_q];
        pix_acc     = bus.pix_valid & pix_ready_c & ~clr;
        row_acc     = row_valid_c & bus.row_ready & ~clr;
        wr_data     = to_fp32(bus.pix_in);
        wr_addr     = {wr_bank_q, wr_cnt_q};

        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_row_d  = rd_row_q;

        if (clr) begin
            full_d    = 2'b00;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_cnt_d  = 6'd0;
            rd_row_d  = 3'd0;
        end else begin
            // Write and read never target the same bank, so both updates can apply.
            if (pix_acc) begin
                wr_cnt_d = wr_cnt_q + 6'd1;
                if (wr_cnt_q == 6'd63) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                end
            end
            if (row_acc) begin
                rd_row_d = rd_row_q + 3'd1;
                if (rd_row_q == 3'd7) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                end
            end
        end
    end

    always_comb begin
        row_vec_c = '0;
        for (int i = 0; i < 8; i++) begin
            row_vec_c[i] = mem_q[{rd_bank_q, rd_row_q, 3'(i)}];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= 6'd0;
            rd_row_q  <= 3'd0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_row_q  <= rd_row_d;
        end
    end

    // Block storage needs no reset; contents are only visible behind full flags.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign bus.pix_ready = pix_ready_c;
    assign bus.row_valid = row_valid_c;
    assign bus.row_vec   = row_vec_c;
    assign bus.row_idx   = rd_row_q;
    assign bus.row_last  = (rd_row_q == 3'd7);

endmodule

// File: tb/tb_fdct_in_buf.sv
// Bench for fdct_in_buf: two instances (LEVEL_SHIFT 128 and 0) share one stimulus
// stream and are compared every cycle against a block-queue reference model.
module tb_fdct_in_buf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic       pix_valid = 1'b0;
    logic       row_ready = 1'b0;

    always #5 clk = ~clk;

    fdct_in_buf_if b128 ();
    fdct_in_buf_if b0 ();

    assign b128.pix_in    = pix_in;
    assign b128.pix_valid = pix_valid;
    assign b128.row_ready = row_ready;
    assign b0.pix_in      = pix_in;
    assign b0.pix_valid   = pix_valid;
    assign b0.row_ready   = row_ready;

    fdct_in_buf #(.LEVEL_SHIFT(128)) u128 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(b128.slave));
    fdct_in_buf #(.LEVEL_SHIFT(0))   u0   (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(b0.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion through the host double format.
    function automatic logic [31:0] fp32(input int v);
        logic [63:0] d;
        logic [31:0] r;
        int          e;
        if (v == 0) return 32'h0;
        d       = $realtobits(real'(v));
        e       = int'(d[62:52]) - 896;
        r[31]   = d[63];
        r[30:23] = 8'(e);
        r[22:0] = d[51:29];
        return r;
    endfunction

    // Reference model: completed blocks waiting for output, plus the block being filled.
    typedef logic [7:0] blk_t [64];
    blk_t pend[$];
    blk_t cur;
    int   cur_n = 0;
    int   m_row = 0;

    task automatic model_reset();
        pend.delete();
        cur_n = 0;
        m_row = 0;
    endtask

    function automatic logic [255:0] exp_row(input int shift);
        logic [7:0][31:0] r;
        for (int c = 0; c < 8; c++) r[c] = fp32(int'(pend[0][8 * m_row + c]) - shift);
        return r;
    endfunction

    initial begin
        bit         pa, ra, cs;
        logic [7:0] pv;
        forever begin
            @(negedge clk);
            pa = 0; ra = 0; cs = 0; pv = 8'd0;
            if (!rst_n) begin
                model_reset();
            end else begin
                bit er, ev;
                er = pend.size() < 2;
                ev = pend.size() > 0;
                check("pix_ready_s128", b128.pix_ready, er);
                check("pix_ready_s0", b0.pix_ready, er);
                check("row_valid_s128", b128.row_valid, ev);
                check("row_valid_s0", b0.row_valid, ev);
                if (ev) begin
                    check("row_idx", b128.row_idx, m_row);
                    check("row_last", b128.row_last, m_row == 7);
                    check("row_vec_s128", b128.row_vec, exp_row(128));
                    check("row_vec_s0", b0.row_vec, exp_row(0));
                end
                pa = pix_valid && er && !clr;
                ra = row_ready && ev && !clr;
                pv = pix_in;
                cs = clr;
            end
            @(posedge clk);
            if (!rst_n || cs) begin
                model_reset();
            end else begin
                if (pa) begin
                    cur[cur_n] = pv;
                    cur_n++;
                    if (cur_n == 64) begin
                        pend.push_back(cur);
                        cur_n = 0;
                    end
                end
                if (ra) begin
                    m_row++;
                    if (m_row == 8) begin
                        pend.delete(0);
                        m_row = 0;
                    end
                end
            end
        end
    end

    // Offer one pixel until accepted; returns the number of stalled cycles.
    task automatic feed(input logic [7:0] p, output int waits);
        waits     = 0;
        pix_valid = 1'b1;
        pix_in    = p;
        forever begin
            bit acc;
            @(negedge clk);
            acc = (b128.pix_ready === 1'b1) && !clr;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 300) begin
                check("feed_timeout", 32'(waits), 0);
                break;
            end
        end
    endtask

    task automatic feed_block(input blk_t b);
        int w;
        for (int k = 0; k < 64; k++) feed(b[k], w);
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the negedge where row 0 is first seen.
    task automatic wait_row0();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(b128.row_valid === 1'b1 && b128.row_idx == 3'd0) && n < 300);
        if (n >= 300) check("wait_row0_timeout", 32'(n), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

    initial begin
        blk_t        b;
        int          w, n;
        logic [31:0] sweep_exp [8];
        logic [7:0]  sweep_pix [8];

        sweep_pix = '{8'd128, 8'd129, 8'd127, 8'd255, 8'd0, 8'd130, 8'd136, 8'd200};
        sweep_exp = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h42FE0000,
                      32'hC3000000, 32'h40000000, 32'h41000000, 32'h42900000};

        // Pin the reference conversion with hand-computed values.
        check("model_m128", fp32(-128), 32'hC3000000);
        check("model_p127", fp32(127), 32'h42FE0000);
        check("model_m1", fp32(-1), 32'hBF800000);
        check("model_p63", fp32(63), 32'h427C0000);
        check("model_p56", fp32(56), 32'h42600000);

        // Asynchronous reset values.
        #1 rst_n = 1'b0;
        #1;
        check("rst_pix_ready", b128.pix_ready, 1);
        check("rst_row_valid", b128.row_valid, 0);
        check("rst_row_idx", b128.row_idx, 0);
        check("rst_row_last", b128.row_last, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero block: every element is -128.0, eight consecutive rows.
        row_ready = 1'b1;
        for (int k = 0; k < 64; k++) b[k] = 8'd0;
        feed_block(b);
        pix_valid = 1'b0;
        wait_row0();
        for (int r = 0; r < 8; r++) begin
            check("zero_row_idx", b128.row_idx, r);
            check("zero_row_last", b128.row_last, r == 7);
            check("zero_row_vec", b128.row_vec, {8{32'hC3000000}});
            if (r < 7) @(negedge clk);
        end
        @(posedge clk);
        #1;

        // Value sweep in row 0.
        for (int k = 0; k < 64; k++) b[k] = (k < 8) ? sweep_pix[k] : 8'($urandom);
        feed_block(b);
        pix_valid = 1'b0;
        wait_row0();
        for (int c = 0; c < 8; c++) check("sweep_elem", b128.row_vec[c], sweep_exp[c]);
        @(posedge clk);
        #1;

        // Index mapping with zero level shift.
        for (int k = 0; k < 64; k++) b[k] = 8'(k);
        feed_block(b);
        pix_valid = 1'b0;
        wait_row0();
        repeat (7) @(negedge clk);
        check("map_row_idx", b0.row_idx, 7);
        check("map_r7c7", b0.row_vec[7], 32'h427C0000);
        check("map_r7c0", b0.row_vec[0], 32'h42600000);
        idle(4);

        // Back-pressure: three blocks with valid held high, rows stalled.
        row_ready = 1'b0;
        for (int blk = 0; blk < 2; blk++) begin
            for (int k = 0; k < 64; k++) b[k] = 8'($urandom);
            feed_block(b);
        end
        for (int k = 0; k < 64; k++) b[k] = 8'($urandom);
        pix_valid = 1'b1;
        pix_in    = b[0];
        repeat (5) begin
            @(negedge clk);
            check("bp_pix_ready_low", b128.pix_ready, 0);
            check("bp_row_held", {b128.row_valid, b128.row_idx}, {1'b1, 3'd0});
        end
        @(posedge clk);
        #1 row_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b128.pix_ready !== 1'b1 && n < 40);
        check("bp_ready_return", 32'(n), 9);
        @(posedge clk);
        #1;
        for (int k = 1; k < 64; k++) feed(b[k], w);
        idle(20);

        // Full-rate ping-pong over ten random blocks.
        row_ready = 1'b1;
        for (int k = 0; k < 640; k++) begin
            feed(8'($urandom), w);
            check("full_rate_stall", 32'(w), 0);
        end
        idle(20);

        // Soft clear with one full bank and a partial block pending.
        row_ready = 1'b0;
        for (int k = 0; k < 84; k++) feed(8'($urandom), w);
        pix_valid = 1'b1;
        pix_in    = 8'hA5;
        clr       = 1'b1;
        @(posedge clk);
        #1;
        clr       = 1'b0;
        pix_valid = 1'b0;
        check("clr_row_valid", b128.row_valid, 0);
        check("clr_pix_ready", b128.pix_ready, 1);
        row_ready = 1'b1;
        for (int k = 0; k < 64; k++) b[k] = 8'($urandom);
        feed_block(b);
        idle(20);

        // Reset mid-read: rows 0..2 taken, row 3 on display.
        row_ready = 1'b0;
        for (int k = 0; k < 64; k++) b[k] = 8'($urandom);
        feed_block(b);
        pix_valid = 1'b0;
        wait_row0();
        @(posedge clk);
        #1 row_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 row_ready = 1'b0;
        check("pre_rst_row_idx", b0.row_idx, 3);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_pix_ready", b128.pix_ready, 1);
        check("mid_rst_row_valid", b128.row_valid, 0);
        check("mid_rst_row_idx", b128.row_idx, 0);
        check("mid_rst_row_last", b128.row_last, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        row_ready = 1'b1;
        for (int k = 0; k < 64; k++) b[k] = 8'($urandom);
        feed_block(b);
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fdct_in_buf.md
Name: fdct_in_buf

Overview:
- Front end of the FDCT datapath.
- Accepts 8-bit pixels in raster order, one 8x8 block at a time, over a valid/ready stream.
- Level-shifts each pixel and converts it exactly to IEEE-754 single precision, then stores it in a ping-pong block buffer.
- Streams each buffered block out as eight row vectors of eight float32 words. The downstream matrix stage multiplies these rows against the DCT coefficient vectors.

Parameters:
- LEVEL_SHIFT, 128, unsigned offset subtracted from every pixel before conversion; legal range 0..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous soft clear of both buffer banks and all counters.
- pix_in  in  8  unsigned pixel sample.
- pix_valid  in  1  pix_in is valid this cycle.
- pix_ready  out  1  block can accept a pixel this cycle.
- row_vec  out  32x8 (array [7:0])  float32 row; element i = column i of the current row.
- row_idx  out  3  row number, 0..7, of row_vec within the block.
- row_last  out  1  high when row_idx == 7.
- row_valid  out  1  row_vec/row_idx/row_last valid.
- row_ready  in  1  consumer accepts the current row.

Behaviour:
- Reset (rst_n low, asynchronous):
  - both bank-full flags, wr_bank, rd_bank, wr_cnt (6b) and rd_row (3b) go to 0;
  - pix_ready goes to 1; row_valid and row_last go to 0; row_idx goes to 0;
  - row_vec contents are don't-care.
- clr (synchronous, takes priority over everything else): same state effect as reset, including discarding a partially written or partially read block; no pixel or row handshake completes in that cycle.
- Conversion (combinational, before the write):
  - v = pix_in - LEVEL_SHIFT, signed 9b, range -255..255;
  - v == 0 gives 32'h00000000;
  - otherwise sign = v<0, m = |v|, p = index of the leading one of m, exponent = 127+p, mantissa = m left-aligned below its leading one, zero-padded to 23b;
  - the result is always exact, with no rounding.
- Write side:
  - pix_ready = ~full[wr_bank];
  - a pixel is accepted when pix_valid & pix_ready; it is written to bank wr_bank at address wr_cnt (row = wr_cnt[5:3], col = wr_cnt[2:0]), then wr_cnt increments;
  - on accepting wr_cnt == 63: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- Read side:
  - row_valid = full[rd_bank];
  - row_vec = bank rd_bank, row rd_row; row_idx = rd_row; row_last = (rd_row == 7);
  - a row completes when row_valid & row_ready, then rd_row increments;
  - on completing row 7: clear full[rd_bank], toggle rd_bank, rd_row wraps to 0.
  - While row_valid is high and row_ready is low, all row outputs hold stable.
- Latency:
  - the 64th pixel accepted at edge N gives row_valid = 1 after edge N, i.e. row 0 is presented in cycle N+1;
  - a bank freed at edge M makes pix_ready 1 in cycle M+1, if that bank is wr_bank.
- Throughput: 1 pixel/cycle in, 1 row/cycle out.
  - A continuous stream sustains full rate: while one bank drains (8 cycles), the other fills (64 cycles).
- Simultaneous events:
  - a write completing one bank and a read freeing the other bank in the same cycle both take effect;
  - a write and a read are never in the same bank, because ping-pong order guarantees wr_bank != rd_bank whenever both are active.
- Full condition: both banks full gives pix_ready = 0; pix_valid is ignored and no counter changes.
- Empty condition: both banks empty gives row_valid = 0; row_ready is ignored.
- Storage is 2x64x32b of flops or distributed RAM, with a read mux on {rd_bank, rd_row}.

Test Plan:
- Single-value conversion:
  - feed 64 pixels that are all 0, LEVEL_SHIFT=128, row_ready=1;
  - every row_vec element must be 32'hC3000000;
  - rows 0..7 appear on 8 consecutive cycles, row_last only on row 7.
- Value sweep, first row of a block:
  - pixels 128,129,127,255,0,130,136,200 must give 32'h00000000, 3F800000, BF800000, 42FE0000, C3000000, 40000000, 41000000, 42900000.
- Back-pressure:
  - stream 3 blocks with pix_valid=1 continuously while row_ready=0;
  - pix_ready must drop after pixel 128; blocks 1 and 2 must be held intact;
  - after releasing row_ready, blocks must emerge in order, and pix_ready must return 1 cycle after block 1's row 7 completes.
- Full-rate ping-pong:
  - random pixels, continuous valid, row_ready=1, for 10 blocks;
  - pix_ready must never drop;
  - each output block must match a reference model bit-exactly.
- Mid-operation clear and reset:
  - assert clr after 20 pixels of block 0, then send a full block;
  - only the new block must be output;
  - repeat with rst_n pulsed low mid-row-read: outputs go to reset values immediately (asynchronously).
- Pixel/row index mapping:
  - block with pixel k = k (k = 0..63), LEVEL_SHIFT=0;
  - row r, col c must equal float(8r+c), e.g. row 7 col 7 = 32'h427C0000.
